// File: rtl/adr_sequencer_pkg.sv
// adr_pkg: address-maker select codes and sequencer state enumeration.
// These select codes are the same ones the address maker decodes.
package adr_pkg;

    typedef enum logic [2:0] {
        adr_none = 3'd0,
        adr_rt   = 3'd1,
        adr_rg   = 3'd2,
        adr_wt   = 3'd3,
        adr_wg   = 3'd4
    } adr_sel_e;

    typedef enum logic [3:0] {
        st_idle,
        st_rd_t,
        st_wait_t,
        st_rd_g,
        st_wait_g,
        st_alu,
        st_wr,
        st_next,
        st_done
    } seq_state_e;

    // Width of the memory-latency counter. MEM_LAT is at most 7.
    localparam int LAT_W = 3;

endpackage

// File: rtl/adr_sequencer_if.sv
// adr_sequencer_if: control/status bundle of the address sequencer.
//   slave  : sequencer side (takes start/abort/alu_done, drives the rest)
//   master : controller/bench side
import adr_pkg::*;

interface adr_sequencer_if #(parameter int PIX_W = 14);
    logic             start;
    logic             abort;
    logic             alu_done;
    adr_sel_e         SEL;
    logic             TOG_inc;
    logic             QUAD_inc;
    logic             mem_re;
    logic             mem_we;
    logic             alu_start;
    logic [1:0]       quad;
    logic [PIX_W-1:0] pix;
    logic             busy;
    logic             done;

    modport slave (
        input  start, abort, alu_done,
        output SEL, TOG_inc, QUAD_inc, mem_re, mem_we, alu_start,
               quad, pix, busy, done
    );

    modport master (
        output start, abort, alu_done,
        input  SEL, TOG_inc, QUAD_inc, mem_re, mem_we, alu_start,
               quad, pix, busy, done
    );
endinterface

// File: rtl/adr_sequencer_lat_timer.sv
// seq_lat_timer: memory read latency counter.
//   load   : arm the counter so that expire is reached after MEM_LAT cycles
//   dec    : count down one step (saturates at zero)
//   clr    : synchronous clear
//   expire : counter is at zero (the current wait cycle is the last one)
import adr_pkg::*;

module seq_lat_timer #(
    parameter int MEM_LAT = 2
) (
    input  logic in_Clock,
    input  logic in_Reset_n,
    input  logic clr,
    input  logic load,
    input  logic dec,
    output logic expire
);
    logic [LAT_W-1:0] cnt;

    always_ff @(posedge in_Clock or negedge in_Reset_n) begin
        if (!in_Reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            // The first wait cycle already counts, hence MEM_LAT-1.
            cnt <= LAT_W'(MEM_LAT - 1);
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);
endmodule

// File: rtl/adr_sequencer.sv
// adr_sequencer: per-pixel read T / read G / ALU / write sequencer over
// four quadrants of PIX_PER_QUAD pixels.
//   in_Clock, in_Reset_n : clock, async active-low reset
//   bus (slave)          : start/abort/alu_done in; SEL, strobes, quad,
//                          pix, busy, done out (all registered)
import adr_pkg::*;

module adr_sequencer #(
    parameter int PIX_W        = 14,
    parameter int PIX_PER_QUAD = 16384,
    parameter int MEM_LAT      = 2
) (
    input  logic            in_Clock,
    input  logic            in_Reset_n,
    adr_sequencer_if.slave  bus
);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_QUAD - 1);

    seq_state_e       state, state_n;
    logic [1:0]       quad_q, quad_n;
    logic [PIX_W-1:0] pix_q, pix_n;
    logic             lat_clr, lat_load, lat_dec, lat_exp;

    // Registered outputs and their next values.
    adr_sel_e sel_q, sel_n;
    logic     re_q, re_n, we_q, we_n, as_q, as_n;
    logic     qi_q, qi_n, ti_q, ti_n, busy_q, busy_n, done_q, done_n;

    seq_lat_timer #(.MEM_LAT(MEM_LAT)) u_lat (
        .in_Clock   (in_Clock),
        .in_Reset_n (in_Reset_n),
        .clr        (lat_clr),
        .load       (lat_load),
        .dec        (lat_dec),
        .expire     (lat_exp)
    );

    // Next state, counters and timer control.
    always_comb begin
        state_n  = state;
        quad_n   = quad_q;
        pix_n    = pix_q;
        lat_clr  = 1'b0;
        lat_load = 1'b0;
        lat_dec  = 1'b0;
        if (bus.abort) begin
            state_n = st_idle;
            quad_n  = '0;
            pix_n   = '0;
            lat_clr = 1'b1;
        end else begin
            case (state)
                st_idle:   if (bus.start) begin
                               state_n = st_rd_t;
                               quad_n  = '0;
                               pix_n   = '0;
                           end
                st_rd_t:   begin state_n = st_wait_t; lat_load = 1'b1; end
                st_wait_t: if (lat_exp) state_n = st_rd_g; else lat_dec = 1'b1;
                st_rd_g:   begin state_n = st_wait_g; lat_load = 1'b1; end
                st_wait_g: if (lat_exp) state_n = st_alu; else lat_dec = 1'b1;
                st_alu:    if (bus.alu_done) state_n = st_wr;
                st_wr:     state_n = st_next;
                st_next:   if (pix_q != PIX_LAST) begin
                               pix_n   = pix_q + 1'b1;
                               state_n = st_rd_t;
                           end else begin
                               pix_n   = '0;
                               quad_n  = quad_q + 2'd1;   // 3 wraps to 0
                               state_n = (quad_q == 2'd3) ? st_done : st_rd_t;
                           end
                st_done:   state_n = st_idle;
                default:   state_n = st_idle;
            endcase
        end
    end

    // Outputs are decoded from the state being entered and registered,
    // so each one is valid for exactly the cycle spent in that state.
    always_comb begin
        sel_n = adr_none;
        case (state_n)
            st_rd_t: sel_n = adr_rt;
            st_rd_g: sel_n = adr_rg;
            st_wr:   sel_n = quad_n[0] ? adr_wg : adr_wt;
            default: sel_n = adr_none;
        endcase
        re_n   = (state_n == st_rd_t) || (state_n == st_rd_g);
        we_n   = (state_n == st_wr);
        as_n   = (state_n == st_alu) && (state != st_alu);
        // pix/quad are stable on the way into NEXT, so the wrap decision
        // can be taken one cycle early.
        qi_n   = (state_n == st_next) && (pix_q == PIX_LAST);
        ti_n   = qi_n && (quad_q != 2'd3);
        busy_n = (state_n != st_idle);
        done_n = (state_n == st_done);
    end

    always_ff @(posedge in_Clock or negedge in_Reset_n) begin
        if (!in_Reset_n) begin
            state  <= st_idle;
            quad_q <= '0;
            pix_q  <= '0;
            sel_q  <= adr_none;
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            as_q   <= 1'b0;
            qi_q   <= 1'b0;
            ti_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            quad_q <= quad_n;
            pix_q  <= pix_n;
            sel_q  <= sel_n;
            re_q   <= re_n;
            we_q   <= we_n;
            as_q   <= as_n;
            qi_q   <= qi_n;
            ti_q   <= ti_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    assign bus.SEL       = sel_q;
    assign bus.mem_re    = re_q;
    assign bus.mem_we    = we_q;
    assign bus.alu_start = as_q;
    assign bus.QUAD_inc  = qi_q;
    assign bus.TOG_inc   = ti_q;
    assign bus.quad      = quad_q;
    assign bus.pix       = pix_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_adr_sequencer.sv
// Scoreboard bench for adr_sequencer: stimulus pushes the frame's expected
// writes/done, a negedge monitor pops and compares, an ALU responder
// answers alu_start with random delays and injects the abort scenario.
import adr_pkg::*;

module tb_adr_sequencer;
    localparam int PIX_W = 2;
    localparam int PPQ   = 2;
    localparam int ML    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adr_sequencer_if #(.PIX_W(PIX_W)) bus();

    adr_sequencer #(.PIX_W(PIX_W), .PIX_PER_QUAD(PPQ), .MEM_LAT(ML)) dut (
        .in_Clock   (clk),
        .in_Reset_n (rst_n),
        .bus        (bus)
    );

    typedef struct {
        int       q;
        int       p;
        adr_sel_e sel;
    } wr_t;

    wr_t exp_wr[$];
    int  done_pending = 0;
    int  checks = 0;
    int  fails  = 0;
    bit  long_next  = 0;
    bit  abort_mode = 0;
    bit  abort_seen = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a frame writes every pixel of every quadrant in
    // order; odd quadrants write G, even quadrants write T.
    task automatic push_frame(bit completes);
        wr_t w;
        for (int q = 0; q < 4; q++)
            for (int p = 0; p < PPQ; p++) begin
                w.q   = q;
                w.p   = p;
                w.sel = (q % 2 == 1) ? adr_wg : adr_wt;
                exp_wr.push_back(w);
            end
        if (completes) done_pending++;
    endtask

    // ---------------- monitor ----------------
    int         cyc = 0, last_rt = 0, n_we = 0, n_qi = 0, n_ti = 0;
    logic [5:0] prev_strb = '0;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        logic [5:0] strb;
        wr_t        e;
        if (!rst_n) begin
            prev_strb = '0;
            prev_done = 1'b0;
            n_we = 0; n_qi = 0; n_ti = 0;
        end else begin
            cyc++;
            strb = {bus.mem_re, bus.mem_we, bus.alu_start,
                    bus.QUAD_inc, bus.TOG_inc, bus.done};
            chk("re_we_exclusive", 32'(bus.mem_re & bus.mem_we), 0);
            chk("strobe_repeat", 32'(strb & prev_strb), 0);
            prev_strb = strb;
            if (bus.mem_we) begin
                n_we++;
                if (exp_wr.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_write: got quad=%0d pix=%0d expected none",
                             bus.quad, bus.pix);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_quad", 32'(bus.quad), 32'(e.q));
                    chk("wr_pix",  32'(bus.pix),  32'(e.p));
                    chk("wr_sel",  32'(bus.SEL),  32'(e.sel));
                end
            end
            if (bus.mem_re) begin
                if (bus.SEL == adr_rt) last_rt = cyc;
                else begin
                    chk("rd_sel", 32'(bus.SEL), 32'(adr_rg));
                    chk("wait_len", 32'(cyc - last_rt), 32'(ML + 1));
                end
            end
            if (bus.QUAD_inc) begin
                n_qi++;
                chk("quad_inc_pix", 32'(bus.pix), 32'(PPQ - 1));
            end
            if (bus.TOG_inc) begin
                n_ti++;
                chk("tog_with_quad", 32'(bus.QUAD_inc), 1);
            end
            if (bus.done) begin
                chk("done_expected", 32'(done_pending > 0), 1);
                if (done_pending > 0) done_pending--;
                chk("writes_left", 32'(exp_wr.size()), 0);
                chk("frame_we", 32'(n_we), 32'(4 * PPQ));
                chk("frame_quad_inc", 32'(n_qi), 4);
                chk("frame_tog_inc", 32'(n_ti), 3);
                chk("done_quad", 32'(bus.quad), 0);
                chk("done_pix", 32'(bus.pix), 0);
            end
            if (prev_done) chk("idle_after_done", 32'(bus.busy), 0);
            prev_done = bus.done;
            if (!bus.busy) begin n_we = 0; n_qi = 0; n_ti = 0; end
        end
    end

    // ---------------- ALU responder ----------------
    initial begin
        bus.alu_done = 1'b0;
        bus.abort    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.alu_start) begin
                int   d;
                bit   bad, alive, do_abort;
                bit   was_long;
                was_long  = long_next;
                long_next = 0;
                d     = was_long ? 50 : $urandom_range(0, 3);
                bad   = 0;
                alive = 1;
                for (int i = 0; i < d && alive; i++) begin
                    @(negedge clk);
                    if (!rst_n || !bus.busy) alive = 0;
                    else if (bus.SEL != adr_none || bus.mem_we || bus.mem_re) bad = 1;
                end
                if (was_long) chk("alu_hold_idle_sel", 32'(bad), 0);
                if (alive) begin
                    do_abort = abort_mode && bus.quad == 2'd2 && bus.pix == PIX_W'(1);
                    bus.alu_done = 1'b1;
                    if (do_abort) bus.abort = 1'b1;
                    @(negedge clk);
                    bus.alu_done = 1'b0;
                    bus.abort    = 1'b0;
                    if (do_abort) begin
                        chk("abort_busy", 32'(bus.busy), 0);
                        chk("abort_quad", 32'(bus.quad), 0);
                        chk("abort_pix",  32'(bus.pix), 0);
                        chk("abort_no_we", 32'(bus.mem_we), 0);
                        chk("abort_no_done", 32'(bus.done), 0);
                        chk("abort_sel", 32'(bus.SEL), 32'(adr_none));
                        exp_wr.delete();
                        abort_mode = 0;
                        abort_seen = 1;
                    end else begin
                        chk("wr_after_alu_done", 32'(bus.mem_we), 1);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(bit completes);
        push_frame(completes);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait for done; in noisy mode start is pulsed randomly while busy and
    // is left high on the DONE cycle itself.
    task automatic wait_done(bit noisy);
        int n = 0;
        while (!bus.done && n < 3000) begin
            @(negedge clk);
            n++;
            if (noisy) bus.start = ($urandom_range(0, 7) == 0);
        end
        if (bus.done) begin
            if (noisy) bus.start = 1'b1;
        end else begin
            checks++; fails++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
            bus.start = 1'b0;
        end
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sel",  32'(bus.SEL), 32'(adr_none));
        chk("rst_quad", 32'(bus.quad), 0);
        chk("rst_pix",  32'(bus.pix), 0);
        chk("rst_strobes", 32'({bus.mem_re, bus.mem_we, bus.alu_start,
                                 bus.QUAD_inc, bus.TOG_inc, bus.done}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain frame.
        pulse_start(1);
        chk("start_accept_re", 32'(bus.mem_re), 1);
        wait_done(0);
        @(negedge clk);

        // Noisy starts while busy and on DONE, then start one cycle later.
        pulse_start(1);
        wait_done(1);
        @(negedge clk);
        chk("start_at_done_ignored", 32'(bus.busy), 0);
        push_frame(1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_after_done_busy", 32'(bus.busy), 1);
        chk("start_after_done_sel", 32'(bus.SEL), 32'(adr_rt));
        wait_done(0);
        @(negedge clk);

        // Long ALU hold on the first pixel.
        long_next = 1;
        pulse_start(1);
        wait_done(0);
        @(negedge clk);

        // Abort together with alu_done at quad 2, pix 1.
        abort_mode = 1;
        pulse_start(0);
        n = 0;
        while (!abort_seen && n < 3000) begin @(negedge clk); n++; end
        chk("abort_reached", 32'(abort_seen), 1);
        abort_mode = 0;
        repeat (20) @(negedge clk);
        chk("abort_stays_idle", 32'(bus.busy), 0);

        // Asynchronous reset in WAIT_G.
        pulse_start(0);
        n = 0;
        while (!(bus.mem_re && bus.SEL == adr_rg) && n < 200) begin @(negedge clk); n++; end
        chk("reached_rd_g", 32'(bus.mem_re), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_sel",  32'(bus.SEL), 32'(adr_none));
        chk("arst_quad", 32'(bus.quad), 0);
        chk("arst_pix",  32'(bus.pix), 0);
        chk("arst_strobes", 32'({bus.mem_re, bus.mem_we, bus.alu_start,
                                  bus.QUAD_inc, bus.TOG_inc, bus.done}), 0);
        exp_wr.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_arst_idle", 32'(bus.busy), 0);

        // Normal frame after reset.
        pulse_start(1);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("no_pending_done", 32'(done_pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
